haar_integral_builder: RTL and testbench
========================================

Name: haar_integral_builder

Overview:
- Upstream neighbour of the HAAR comparison stage.
- Accepts a raster-order stream of 8-bit grayscale pixels for one 20x20 detection window.
- Builds the 32-bit integral image in a flat 400-entry register buffer (index y*20+x).
- Asserts START to the comparison stage once the window is complete, and holds buffer and START stable until the consumer releases it.

Parameters:
- WIN_W, 20, window width in pixels
- WIN_H, 20, window height in pixels
- PIX_W, 8, pixel width in bits
- II_W, 32, integral entry width in bits (unsigned)

Ports:
- CLK  in  1  system clock, rising edge
- RESET_N  in  1  asynchronous active-low reset
- PIX_DATA  in  PIX_W  pixel value, unsigned
- PIX_VALID  in  1  pixel present
- PIX_SOF  in  1  qualifies PIX_DATA as window pixel (0,0); sampled only when PIX_VALID
- PIX_READY  out  1  builder can accept a pixel
- integral_buffer  out  II_W x WIN_W*WIN_H  integral image, index y*WIN_W+x
- START  out  1  buffer complete and stable
- CONSUMED  in  1  single-cycle pulse from consumer releasing the buffer

Behaviour:
- Reset (async assert, sync release): state IDLE; integral_buffer all 0; START=0; PIX_READY=0 during reset; x=y=0; row sum=0.
- Transfer: a pixel is accepted on a rising edge with PIX_VALID && PIX_READY.
- States:
  - IDLE: PIX_READY=1. Pixels without PIX_SOF are dropped (accepted, not stored). An accepted SOF pixel is stored at (0,0); go to ACCUM.
  - ACCUM: PIX_READY=1. Each accepted pixel is stored at (x,y); x increments and wraps to 0 at WIN_W-1, incrementing y. The accept at (WIN_W-1,WIN_H-1) goes to DONE.
  - DONE: PIX_READY=0, START=1, integral_buffer frozen. CONSUMED goes to IDLE with START=0 next cycle. CONSUMED in IDLE or ACCUM is ignored.
- Arithmetic, per accepted pixel p at (x,y):
  - rs = (x==0 ? 0 : row_sum) + p
  - ii(x,y) = rs + (y==0 ? 0 : ii(x,y-1))
  - row_sum <= rs
  - ii(x,y-1) is read from integral_buffer at (y-1)*WIN_W+x.
  - All arithmetic is unsigned, zero-extended to II_W. The maximum is 400*255 = 102000, so no overflow at defaults.
- Latency:
  - The entry is visible on integral_buffer the cycle after acceptance.
  - START rises the cycle after the last pixel is accepted.
  - Throughput is 1 pixel/cycle.
- SOF inside ACCUM: restart the window. The pixel is written at (0,0), x=1, y=0, row_sum=p. Stale entries are overwritten as the new window fills.
- SOF on the final pixel position: the restart rule takes precedence and no DONE occurs.
- PIX_VALID in DONE: not accepted; the producer must hold the pixel.
- Entries not yet written in the current window keep prior values. START never asserts before all 400 entries are written in that window.
- Reset mid-window or in DONE: immediate return to reset values. The partial window is discarded.

Optional Feature:
- Macro: HAAR_SQ_SUM_EN.
- Defined:
  - Extra output port SQ_SUM (out, 32 bits) = sum of p*p over the window.
  - Accumulates on each accept; cleared to the current p*p on SOF.
  - Reset value 0; frozen in DONE. Intended for variance normalisation downstream.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- All pixels 1, SOF on first -> integral_buffer[y*20+x] = (x+1)*(y+1); [399]=400; START high exactly 1 cycle after the 400th accept.
- All pixels 255 -> [0]=255, [19]=5100, [380]=5100, [399]=102000. With HAAR_SQ_SUM_EN: SQ_SUM=26010000.
- Pixel = x (row ramp 0..19) -> [19]=190, [399]=3800. Toggle PIX_VALID randomly -> same values, no dropped or duplicated pixels.
- Complete window, hold CONSUMED low 50 cycles while PIX_VALID=1 -> PIX_READY=0, buffer unchanged. Pulse CONSUMED -> START low next cycle, IDLE accepts the next SOF.
- 150 pixels of value 7, then SOF + 400 pixels of value 1 -> final [399]=400, START once. Non-SOF pixels in IDLE are ignored.
- RESET_N low mid-ACCUM (pixel 200) and during DONE -> START=0 and all entries 0 asynchronously. The next full window yields correct values.

Source files
------------

// File: rtl/haar_integral_builder_if.sv
// rtl/haar_integral_builder_if.sv - pixel stream handshake between producer and integral builder
interface haar_integral_builder_if #(
  parameter int PIX_W = 8
);
  logic [PIX_W-1:0] PIX_DATA;
  logic             PIX_VALID;
  logic             PIX_SOF;
  logic             PIX_READY;

  modport master (output PIX_DATA, PIX_VALID, PIX_SOF, input PIX_READY);
  modport slave  (input PIX_DATA, PIX_VALID, PIX_SOF, output PIX_READY);
endinterface

// File: rtl/haar_integral_builder.sv
// rtl/haar_integral_builder.sv - builds a WIN_W x WIN_H integral image from a raster pixel stream
// Optional HAAR_SQ_SUM_EN adds SQ_SUM, the per-window sum of squared pixels.
module haar_integral_builder #(
  parameter int WIN_W = 20,
  parameter int WIN_H = 20,
  parameter int PIX_W = 8,
  parameter int II_W  = 32
) (
  input  logic                 CLK,
  input  logic                 RESET_N,
  haar_integral_builder_if.slave pix,
  output logic [II_W-1:0]      integral_buffer [WIN_W*WIN_H],
  output logic                 START,
  input  logic                 CONSUMED
`ifdef HAAR_SQ_SUM_EN
  ,
  output logic [31:0]          SQ_SUM
`endif
);
  localparam int N     = WIN_W * WIN_H;
  localparam int IDX_W = $clog2(N);
  localparam int X_W   = $clog2(WIN_W);
  localparam int Y_W   = $clog2(WIN_H);

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;
  state_t state, state_nxt;

  logic [X_W-1:0]   x;
  logic [Y_W-1:0]   y;
  logic [PIX_W-1:0] p;
  logic [II_W-1:0]  p_ext, row_sum, rs, up, ii_val;
  logic [IDX_W-1:0] wr_idx, up_idx;
  logic             accept, sof, store, x_last, last;

  assign p      = pix.PIX_DATA;
  assign p_ext  = II_W'(p);
  assign accept = pix.PIX_VALID && pix.PIX_READY;
  assign sof    = accept && pix.PIX_SOF;
  assign store  = sof || (accept && state == ACCUM);
  assign x_last = (x == X_W'(WIN_W - 1));
  assign last   = x_last && (y == Y_W'(WIN_H - 1));

  // An SOF pixel always lands at (0,0) with no left or upper neighbour.
  assign wr_idx = sof ? '0 : IDX_W'(int'(y) * WIN_W + int'(x));
  assign up_idx = wr_idx - IDX_W'(WIN_W);
  assign rs     = ((sof || x == '0) ? '0 : row_sum) + p_ext;
  assign up     = (sof || y == '0) ? '0 : integral_buffer[up_idx];
  assign ii_val = rs + up;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    pix.PIX_READY = 1'b0;
    START         = 1'b0;
    case (state)
      IDLE: begin
        pix.PIX_READY = RESET_N;
        if (pix.PIX_VALID && pix.PIX_SOF) state_nxt = ACCUM;
      end
      ACCUM: begin
        pix.PIX_READY = RESET_N;
        if (pix.PIX_VALID && !pix.PIX_SOF && last) state_nxt = DONE;
      end
      DONE: begin
        START = 1'b1;
        if (CONSUMED) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      x       <= '0;
      y       <= '0;
      row_sum <= '0;
      for (int i = 0; i < N; i++) integral_buffer[i] <= '0;
    end else if (store) begin
      integral_buffer[wr_idx] <= ii_val;
      row_sum                 <= rs;
      if (sof) begin
        x <= X_W'(1);
        y <= '0;
      end else if (x_last) begin
        x <= '0;
        y <= last ? '0 : y + Y_W'(1);
      end else begin
        x <= x + X_W'(1);
      end
    end
  end

`ifdef HAAR_SQ_SUM_EN
  logic [31:0] sq;
  assign sq = 32'(p) * 32'(p);

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      SQ_SUM <= '0;
    end else if (store) begin
      SQ_SUM <= (sof ? 32'd0 : SQ_SUM) + sq;
    end
  end
`endif
endmodule

// File: tb/tb_haar_integral_builder.sv
// tb/tb_haar_integral_builder.sv - randomized self-checking bench for haar_integral_builder
module tb_haar_integral_builder;
  localparam int W = 20;
  localparam int H = 20;
  localparam int N = W * H;

  logic        CLK = 1'b0;
  logic        RESET_N;
  logic        START;
  logic        CONSUMED;
  logic [31:0] ib [N];
`ifdef HAAR_SQ_SUM_EN
  logic [31:0] SQ_SUM;
`endif

  haar_integral_builder_if #(.PIX_W(8)) pix ();

  haar_integral_builder #(.WIN_W(W), .WIN_H(H), .PIX_W(8), .II_W(32)) dut (
    .CLK             (CLK),
    .RESET_N         (RESET_N),
    .pix             (pix),
    .integral_buffer (ib),
    .START           (START),
    .CONSUMED        (CONSUMED)
`ifdef HAAR_SQ_SUM_EN
    ,
    .SQ_SUM          (SQ_SUM)
`endif
  );

  always #5 CLK = ~CLK;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] mbuf [N];
  int          img [N];
  int          cnt;
  bit          active;
  bit          mdone;
  longint      msq;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) mbuf[i] = '0;
    cnt = 0; active = 0; mdone = 0; msq = 0;
  endtask

  // Reference: each written entry is the rectangle sum of this window's pixels.
  task automatic model_accept(input int p, input bit sof);
    int s, px, py;
    if (sof) begin
      active = 1; cnt = 0; msq = 0;
    end
    if (active) begin
      img[cnt] = p;
      msq += longint'(p) * p;
      px = cnt % W;
      py = cnt / W;
      s = 0;
      for (int yy = 0; yy <= py; yy++)
        for (int xx = 0; xx <= px; xx++) s += img[yy * W + xx];
      mbuf[cnt] = 32'(s);
      cnt++;
      if (cnt == N) begin
        mdone = 1; active = 0;
      end
    end
  endtask

  task automatic check_buffer(input string tag);
    for (int i = 0; i < N; i++) check($sformatf("%s[%0d]", tag, i), ib[i], mbuf[i]);
  endtask

  task automatic send(input int p, input bit sof);
    bit acc = 0;
    for (int t = 0; t < 100 && !acc; t++) begin
      pix.PIX_DATA  = 8'(p);
      pix.PIX_SOF   = sof;
      pix.PIX_VALID = 1'b1;
      CONSUMED      = !mdone && ($urandom_range(15) == 0);
      acc = pix.PIX_READY;
      @(posedge CLK); #1;
      if (acc) begin
        model_accept(p, sof);
        check("start", START, 32'(mdone));
      end
      @(negedge CLK);
    end
    pix.PIX_VALID = 1'b0;
    CONSUMED      = 1'b0;
    if (!acc) check("ready_timeout", 32'(acc), 1);
  endtask

  task automatic gap();
    int n = ($urandom_range(3) == 0) ? $urandom_range(3, 1) : 0;
    repeat (n) @(negedge CLK);
  endtask

  function automatic int pixel_of(input int kind, input int i);
    case (kind)
      0: return 1;
      1: return 255;
      2: return i % W;
      4: return 7;
      default: return int'($urandom_range(255));
    endcase
  endfunction

  task automatic send_pixels(input int kind, input int first, input int count);
    for (int i = first; i < first + count; i++) begin
      gap();
      send(pixel_of(kind, i), (i == 0));
    end
  endtask

  task automatic consume();
    CONSUMED      = 1'b1;
    pix.PIX_VALID = 1'b0;
    @(posedge CLK); #1;
    mdone = 0; active = 0;
    check("start_after_consume", START, 0);
    check("ready_after_consume", pix.PIX_READY, 1);
    @(negedge CLK);
    CONSUMED = 1'b0;
  endtask

  task automatic finish_window(input string tag);
    check({tag, "_start"}, START, 32'(mdone));
    check({tag, "_ready"}, pix.PIX_READY, 0);
    check_buffer(tag);
`ifdef HAAR_SQ_SUM_EN
    check({tag, "_sq_sum"}, SQ_SUM, 32'(msq));
`endif
    consume();
  endtask

  task automatic reset_pulse(input string tag);
    #2 RESET_N = 1'b0;
    #1;
    model_reset();
    check({tag, "_start"}, START, 0);
    check({tag, "_ready"}, pix.PIX_READY, 0);
    check_buffer(tag);
    @(negedge CLK);
    RESET_N = 1'b1;
  endtask

  initial begin
    RESET_N = 1'b0; CONSUMED = 1'b0;
    pix.PIX_VALID = 1'b0; pix.PIX_SOF = 1'b0; pix.PIX_DATA = '0;
    model_reset();
    #2;
    check("reset_ready", pix.PIX_READY, 0);
    check("reset_start", START, 0);
    check_buffer("reset");
    @(negedge CLK); @(negedge CLK);
    RESET_N = 1'b1;

    for (int i = 0; i < 5; i++) send(int'($urandom_range(255)), 0);
    check("idle_drop", ib[0], 0);

    send_pixels(0, 0, N);
    check("ones_399", ib[399], 400);
    check("ones_21", ib[21], 4);
    pix.PIX_DATA = 8'd9; pix.PIX_SOF = 1'b1; pix.PIX_VALID = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(posedge CLK); #1;
      check("hold_ready", pix.PIX_READY, 0);
    end
    @(negedge CLK);
    finish_window("ones");

    send_pixels(1, 0, N);
    check("max_0", ib[0], 255);
    check("max_19", ib[19], 5100);
    check("max_380", ib[380], 5100);
    check("max_399", ib[399], 102000);
`ifdef HAAR_SQ_SUM_EN
    check("max_sq", SQ_SUM, 26010000);
`endif
    finish_window("max");

    send_pixels(2, 0, N);
    check("ramp_19", ib[19], 190);
    check("ramp_399", ib[399], 3800);
    finish_window("ramp");

    send_pixels(4, 0, 150);
    send_pixels(0, 0, N);
    check("restart_399", ib[399], 400);
    finish_window("restart");

    send_pixels(3, 0, N - 1);
    send(int'($urandom_range(255)), 1);
    check("sof_last_start", START, 0);
    send_pixels(3, 1, N - 1);
    finish_window("sof_last");

    send_pixels(3, 0, 200);
    reset_pulse("rst_accum");
    send_pixels(3, 0, N);
    finish_window("after_rst_accum");

    send_pixels(3, 0, N);
    check("done_start", START, 1);
    reset_pulse("rst_done");
    send_pixels(3, 0, N);
    finish_window("after_rst_done");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
